// File: rtl/uart_transmitter.sv
// 8-bit UART transmitter with 16x oversampled bit timing, optional parity,
// 1 or 2 stop bits and a one-entry holding register for gapless streaming.
module uart_transmitter #(
  parameter int unsigned CLOCK_RATE = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       txStart,
  input  logic [7:0] txData,
  output logic       tx,
  output logic       txReady,
  output logic       txBusy,
  output logic       txDone
);

  localparam int unsigned DIV   = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int unsigned CNT_W = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam logic [CNT_W-1:0] TICK_MAX  = CNT_W'(DIV);
  localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic             PAR_INV   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [3:0]       os_q, os_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic       tick, bit_end, accept, direct_load, reload_hold;
  logic [7:0] load_byte;

  assign tick    = (tick_q == TICK_MAX);
  assign bit_end = tick && (os_q == 4'hF);
  assign accept  = txStart && !hold_full_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    os_d        = os_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    direct_load = 1'b0;
    reload_hold = 1'b0;
    load_byte   = txData;

    if (state_q != IDLE) begin
      tick_d = tick ? '0 : tick_q + CNT_W'(1);
      if (tick) os_d = os_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        tick_d = '0;
        os_d   = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (accept) direct_load = 1'b1;
      end
      START_BIT: begin
        if (bit_end) begin
          state_d = DATA_BITS;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA_BITS: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY_BIT;
              tx_d    = parity_q;
            end else begin
              state_d = STOP_BIT;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[bit_q + 3'd1];
          end
        end
      end
      PARITY_BIT: begin
        if (bit_end) begin
          state_d = STOP_BIT;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          if (bit_q == LAST_STOP) begin
            done_d = 1'b1;
            if (hold_full_q) begin
              reload_hold = 1'b1;
            end else if (accept) begin
              direct_load = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        tick_d  = '0;
        os_d    = '0;
        bit_d   = '0;
      end
    endcase

    // Start a new frame straight from txData or from the holding register
    if (direct_load || reload_hold) begin
      load_byte = reload_hold ? hold_q : txData;
      state_d   = START_BIT;
      shift_d   = load_byte;
      parity_d  = (^load_byte) ^ PAR_INV;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
      tick_d    = '0;
      os_d      = '0;
      bit_d     = '0;
    end

    if (reload_hold) begin
      hold_full_d = 1'b0;
    end else if (accept && !direct_load &&
                 (state_q inside {START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT})) begin
      hold_d      = txData;
      hold_full_d = 1'b1;
    end

    ready_d = !hold_full_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      os_q        <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      os_q        <= os_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tx      = tx_q;
  assign txReady = ready_q;
  assign txBusy  = busy_q;
  assign txDone  = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a frame-timing model checked every cycle on two
// instances (8N1 and 8E2), plus hand-computed line samples.
module tb_uart_transmitter;

  localparam int BIT_CLK = 80;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start [2];
  logic [7:0] tx_data  [2];
  logic       tx_o     [2];
  logic       rdy_o    [2];
  logic       busy_o   [2];
  logic       done_o   [2];

  uart_transmitter #(.CLOCK_RATE(64), .BAUD_RATE(1)) dut (
    .clk(clk), .reset(reset), .txStart(tx_start[0]), .txData(tx_data[0]),
    .tx(tx_o[0]), .txReady(rdy_o[0]), .txBusy(busy_o[0]), .txDone(done_o[0])
  );

  uart_transmitter #(.CLOCK_RATE(64), .BAUD_RATE(1), .PARITY_EN(1),
                     .PARITY_ODD(0), .STOP_BITS(2)) dut_p (
    .clk(clk), .reset(reset), .txStart(tx_start[1]), .txData(tx_data[1]),
    .tx(tx_o[1]), .txReady(rdy_o[1]), .txBusy(busy_o[1]), .txDone(done_o[1])
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int off    = 0;

  task automatic chk(input string nm, input int k, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %b required %b at %0t", nm, k, got, exp, $time);
    end
  endtask

  // Instance 0: 8N1 (10 bits); instance 1: 8E2 (12 bits)
  function automatic int flen(input int k);
    return (k == 0) ? 10 * BIT_CLK : 12 * BIT_CLK;
  endfunction

  function automatic logic exp_bit(input int k, input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[3'(idx - 1)];
    if (idx == 9 && k == 1) return ^b;
    return 1'b1;
  endfunction

  // Model: position within the current frame plus a one-byte holding slot
  logic       m_busy [2];
  logic       m_hf   [2];
  logic       m_done [2];
  logic       m_acc  [2];
  int         m_t    [2];
  logic [7:0] m_cur  [2];
  logic [7:0] m_hold [2];

  always_comb begin
    for (int k = 0; k < 2; k++) m_acc[k] = tx_start[k] && !m_hf[k];
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] <= 1'b0; m_hf[k] <= 1'b0; m_done[k] <= 1'b0;
        m_t[k] <= 0; m_cur[k] <= 8'h00; m_hold[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_done[k] <= 1'b0;
        if (!m_busy[k]) begin
          if (m_acc[k]) begin
            m_busy[k] <= 1'b1; m_t[k] <= 0; m_cur[k] <= tx_data[k];
          end
        end else if (m_t[k] + 1 == flen(k)) begin
          m_done[k] <= 1'b1;
          m_t[k]    <= 0;
          if (m_hf[k]) begin
            m_cur[k] <= m_hold[k]; m_hf[k] <= 1'b0;
          end else if (m_acc[k]) begin
            m_cur[k] <= tx_data[k];
          end else begin
            m_busy[k] <= 1'b0;
          end
        end else begin
          m_t[k] <= m_t[k] + 1;
          if (m_acc[k]) begin
            m_hold[k] <= tx_data[k]; m_hf[k] <= 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("model_tx", k, tx_o[k], m_busy[k] ? exp_bit(k, m_cur[k], m_t[k] / BIT_CLK) : 1'b1);
      chk("model_txReady", k, rdy_o[k], !m_hf[k]);
      chk("model_txBusy", k, busy_o[k], m_busy[k]);
      chk("model_txDone", k, done_o[k], m_done[k]);
    end
  end

  task automatic goto(input int target);
    repeat (target - off) @(posedge clk);
    off = target;
    #2;
  endtask

  task automatic send(input int k, input logic [7:0] b);
    @(posedge clk);
    #1 tx_start[k] = 1'b1; tx_data[k] = b;
    @(posedge clk);
    off = 0;
    #1 tx_start[k] = 1'b0; tx_data[k] = 8'h00;
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tx_start[k] = 1'b0; tx_data[k] = 8'h00;
    end
    #12;
    chk("reset_tx", 0, tx_o[0], 1'b1);
    chk("reset_txReady", 0, rdy_o[0], 1'b1);
    chk("reset_txBusy", 0, busy_o[0], 1'b0);
    chk("reset_txDone", 0, done_o[0], 1'b0);
    @(posedge clk);
    #3 reset = 1'b0;
    repeat (5) @(posedge clk);

    // Single 0xA5 frame, 8N1
    send(0, 8'hA5);
    #1 chk("a5_start_tx", 0, tx_o[0], 1'b0);
    chk("a5_start_busy", 0, busy_o[0], 1'b1);
    goto(40);  chk("a5_start_mid", 0, tx_o[0], 1'b0);
    goto(120); chk("a5_bit0", 0, tx_o[0], 1'b1);
    goto(200); chk("a5_bit1", 0, tx_o[0], 1'b0);
    goto(600); chk("a5_bit6", 0, tx_o[0], 1'b0);
    goto(680); chk("a5_bit7", 0, tx_o[0], 1'b1);
    goto(760); chk("a5_stop", 0, tx_o[0], 1'b1);
    goto(799); chk("a5_done_early", 0, done_o[0], 1'b0);
    goto(800); chk("a5_done", 0, done_o[0], 1'b1);
    chk("a5_idle_busy", 0, busy_o[0], 1'b0);
    goto(801); chk("a5_done_pulse", 0, done_o[0], 1'b0);
    repeat (20) @(posedge clk);

    // Back-to-back 0x55 then 0x0F, plus an ignored 0xFF while holding is full
    @(posedge clk);
    #1 tx_start[0] = 1'b1; tx_data[0] = 8'h55;
    @(posedge clk);
    off = 0;
    #1 tx_data[0] = 8'h0F;
    @(posedge clk);
    off = 1;
    #1 tx_start[0] = 1'b0; tx_data[0] = 8'hFF;
    #1 chk("b2b_ready_low", 0, rdy_o[0], 1'b0);
    goto(10);
    tx_start[0] = 1'b1; tx_data[0] = 8'hFF;
    @(posedge clk);
    off = 11;
    #1 tx_start[0] = 1'b0;
    goto(120);  chk("b2b_55_bit0", 0, tx_o[0], 1'b1);
    goto(200);  chk("b2b_55_bit1", 0, tx_o[0], 1'b0);
    goto(400);  chk("b2b_ready_mid", 0, rdy_o[0], 1'b0);
    goto(799);  chk("b2b_stop", 0, tx_o[0], 1'b1);
    goto(800);  chk("b2b_done1", 0, done_o[0], 1'b1);
    chk("b2b_f2_start", 0, tx_o[0], 1'b0);
    chk("b2b_ready_back", 0, rdy_o[0], 1'b1);
    chk("b2b_busy", 0, busy_o[0], 1'b1);
    goto(920);  chk("b2b_0f_bit0", 0, tx_o[0], 1'b1);
    goto(1240); chk("b2b_0f_bit4", 0, tx_o[0], 1'b0);
    goto(1600); chk("b2b_done2", 0, done_o[0], 1'b1);
    chk("b2b_end_busy", 0, busy_o[0], 1'b0);
    repeat (20) @(posedge clk);

    // Accept in the very cycle the stop bit ends with holding empty
    send(0, 8'h3C);
    goto(799);
    tx_start[0] = 1'b1; tx_data[0] = 8'hC3;
    @(posedge clk);
    off = 800;
    #1 tx_start[0] = 1'b0; tx_data[0] = 8'h00;
    #1 chk("direct_start", 0, tx_o[0], 1'b0);
    chk("direct_ready", 0, rdy_o[0], 1'b1);
    goto(880);  chk("direct_c3_bit0", 0, tx_o[0], 1'b1);
    goto(1600); chk("direct_done", 0, done_o[0], 1'b1);
    repeat (20) @(posedge clk);

    // Reset in the middle of a 0x00 frame with a byte held
    send(0, 8'h00);
    tx_start[0] = 1'b1; tx_data[0] = 8'h99;
    @(posedge clk);
    off = 1;
    #1 tx_start[0] = 1'b0;
    goto(2);   chk("held_ready", 0, rdy_o[0], 1'b0);
    goto(300); chk("abort_line_low", 0, tx_o[0], 1'b0);
    reset = 1'b1;
    #1 chk("abort_tx", 0, tx_o[0], 1'b1);
    chk("abort_ready", 0, rdy_o[0], 1'b1);
    chk("abort_busy", 0, busy_o[0], 1'b0);
    chk("abort_done", 0, done_o[0], 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("abort_no_done", 0, done_o[0], 1'b0);
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    send(0, 8'h81);
    #1 chk("post_reset_start", 0, tx_o[0], 1'b0);
    chk("post_reset_busy", 0, busy_o[0], 1'b1);
    goto(120); chk("x81_bit0", 0, tx_o[0], 1'b1);
    goto(200); chk("x81_bit1", 0, tx_o[0], 1'b0);
    goto(680); chk("x81_bit7", 0, tx_o[0], 1'b1);
    goto(800); chk("x81_done", 0, done_o[0], 1'b1);
    repeat (20) @(posedge clk);

    // 8E2 frame with 0x07
    send(1, 8'h07);
    goto(120); chk("p07_bit0", 1, tx_o[1], 1'b1);
    goto(360); chk("p07_bit3", 1, tx_o[1], 1'b0);
    goto(760); chk("p07_parity", 1, tx_o[1], 1'b1);
    goto(840); chk("p07_stop1", 1, tx_o[1], 1'b1);
    goto(920); chk("p07_stop2", 1, tx_o[1], 1'b1);
    chk("p07_stop2_busy", 1, busy_o[1], 1'b1);
    goto(959); chk("p07_done_early", 1, done_o[1], 1'b0);
    goto(960); chk("p07_done", 1, done_o[1], 1'b1);
    chk("p07_end_busy", 1, busy_o[1], 1'b0);
    repeat (10) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
